// File: rtl/io_stim_driver.sv
// io_stim_driver: multi-channel stimulus generator for switch/button style
// inputs. After a start delay it steps through CONST / INC / WALK / LFSR
// patterns, holding each one for HOLD_CYCLES cycles, and reports valid,
// step index and completion.
//
// Optional feature: define IO_STIM_DRIVER_BOUNCE_EN to add contact bounce
// (BOUNCE_CYCLES alternating new/old cycles at the start of every pattern
// after the first). Without the macro, o_valid stays high throughout DRIVE.
module io_stim_driver #(
  parameter int          NUM_CH      = 2,
  parameter int          WIDTH       = 32,
  parameter int          START_DELAY = 3,
  parameter int          HOLD_CYCLES = 4,
  parameter int          NUM_STEPS   = 8,
  parameter logic [31:0] LFSR_TAPS   = 32'h8020_0003
`ifdef IO_STIM_DRIVER_BOUNCE_EN
  ,
  parameter int          BOUNCE_CYCLES = 2
`endif
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic [1:0]              i_mode,
  input  logic [NUM_CH*WIDTH-1:0] i_seed,
  output logic [NUM_CH*WIDTH-1:0] o_stim,
  output logic                    o_valid,
  output logic [31:0]             o_step,
  output logic                    o_done
);

  localparam int               CW     = NUM_CH * WIDTH;
  localparam logic [WIDTH-1:0] TAPS_W = WIDTH'(LFSR_TAPS);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DRIVE, ST_DONE} state_e;
  typedef enum logic [1:0] {MODE_CONST, MODE_INC, MODE_WALK, MODE_LFSR} mode_e;

  // First pattern of a run for channel c.
  function automatic logic [WIDTH-1:0] pat_first(input mode_e m,
                                                 input logic [WIDTH-1:0] seed,
                                                 input int c);
    logic [WIDTH-1:0] one;
    one = '0;
    one[0] = 1'b1;
    pat_first = seed;
    case (m)
      MODE_WALK: pat_first = one << (c % WIDTH);
      MODE_LFSR: pat_first = (seed == '0) ? one : seed;
      default:   pat_first = seed;
    endcase
  endfunction

  // Pattern for step n+1 given the pattern for step n.
  function automatic logic [WIDTH-1:0] pat_next(input mode_e m,
                                                input logic [WIDTH-1:0] x);
    pat_next = x;
    case (m)
      MODE_INC:  pat_next = x + WIDTH'(1);
      MODE_WALK: pat_next = {x[WIDTH-2:0], x[WIDTH-1]};
      MODE_LFSR: pat_next = (x >> 1) ^ (x[0] ? TAPS_W : '0);
      default:   pat_next = x;
    endcase
  endfunction

`ifdef IO_STIM_DRIVER_BOUNCE_EN
  // Bounce cycle h shows the new pattern when an even number of bounce
  // cycles remain after it, so the final bounce cycle always shows new.
  function automatic logic bounce_new(input logic [31:0] h);
    bounce_new = (((BOUNCE_CYCLES - 1 - int'(h)) % 2) == 0);
  endfunction
`endif

  state_e         state_q, state_d;
  mode_e          mode_q, mode_d;
  logic [CW-1:0]  seed_q, seed_d;
  logic [CW-1:0]  pat_q, pat_d;
  logic [31:0]    wait_q, wait_d;
  logic [31:0]    hold_q, hold_d;
  logic [31:0]    step_q, step_d;
  logic           valid_q, valid_d;
  logic           done_q, done_d;

  logic           do_load, do_adv, do_hold_inc;
  mode_e          ld_mode;
  logic [CW-1:0]  ld_seed;

`ifdef IO_STIM_DRIVER_BOUNCE_EN
  logic [CW-1:0]  prev_q, prev_d;
  logic [CW-1:0]  stim_q, stim_d;
`endif

  // Next-state and next-output computation for the run sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latches).
    state_d     = state_q;
    mode_d      = mode_q;
    seed_d      = seed_q;
    pat_d       = pat_q;
    wait_d      = wait_q;
    hold_d      = hold_q;
    step_d      = step_q;
    valid_d     = valid_q;
    done_d      = done_q;
    do_load     = 1'b0;
    do_adv      = 1'b0;
    do_hold_inc = 1'b0;
    ld_mode     = mode_q;
    ld_seed     = seed_q;

    case (state_q)
      ST_IDLE: begin
        if (i_en) begin
          mode_d = mode_e'(i_mode);
          seed_d = i_seed;
          if (START_DELAY == 0) begin
            do_load = 1'b1;
            ld_mode = mode_e'(i_mode);
            ld_seed = i_seed;
          end else begin
            state_d = ST_WAIT;
            wait_d  = '0;
          end
        end
      end
      ST_WAIT: begin
        if (!i_en) begin
          state_d = ST_IDLE;
          wait_d  = '0;
        end else if (wait_q == 32'(START_DELAY - 1)) begin
          do_load = 1'b1;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      ST_DRIVE: begin
        // With i_en low nothing changes: the pattern, step and hold freeze.
        if (i_en) begin
          if (hold_q == 32'(HOLD_CYCLES - 1)) begin
            hold_d = '0;
            if ((NUM_STEPS != 0) && (step_q == 32'(NUM_STEPS - 1))) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              valid_d = 1'b0;
            end else begin
              do_adv = 1'b1;
              step_d = step_q + 32'd1;
              for (int c = 0; c < NUM_CH; c++) begin
                pat_d[c*WIDTH +: WIDTH] = pat_next(mode_q, pat_q[c*WIDTH +: WIDTH]);
              end
            end
          end else begin
            do_hold_inc = 1'b1;
            hold_d      = hold_q + 32'd1;
          end
        end
      end
      ST_DONE: begin
        if (!i_en) begin
          state_d = ST_IDLE;
          pat_d   = '0;
          step_d  = '0;
          hold_d  = '0;
          valid_d = 1'b0;
          done_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_load) begin
      state_d = ST_DRIVE;
      valid_d = 1'b1;
      step_d  = '0;
      hold_d  = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        pat_d[c*WIDTH +: WIDTH] = pat_first(ld_mode, ld_seed[c*WIDTH +: WIDTH], c);
      end
    end

`ifdef IO_STIM_DRIVER_BOUNCE_EN
    prev_d = prev_q;
    stim_d = stim_q;
    if (do_load) begin
      prev_d = pat_d;
      stim_d = pat_d;
    end else if (do_adv) begin
      prev_d = pat_q;
      if (BOUNCE_CYCLES > 0) begin
        stim_d  = bounce_new(32'd0) ? pat_d : pat_q;
        valid_d = 1'b0;
      end else begin
        stim_d  = pat_d;
        valid_d = 1'b1;
      end
    end else if (do_hold_inc) begin
      if ((step_q != '0) && (hold_d < 32'(BOUNCE_CYCLES))) begin
        stim_d  = bounce_new(hold_d) ? pat_q : prev_q;
        valid_d = 1'b0;
      end else begin
        stim_d  = pat_q;
        valid_d = 1'b1;
      end
    end else if ((state_q == ST_DONE) && !i_en) begin
      prev_d = '0;
      stim_d = '0;
    end
`endif
  end

  // State and output registers; synchronous active-high reset wins over all.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (i_rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_CONST;
      seed_q  <= '0;
      pat_q   <= '0;
      wait_q  <= '0;
      hold_q  <= '0;
      step_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef IO_STIM_DRIVER_BOUNCE_EN
      prev_q  <= '0;
      stim_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      seed_q  <= seed_d;
      pat_q   <= pat_d;
      wait_q  <= wait_d;
      hold_q  <= hold_d;
      step_q  <= step_d;
      valid_q <= valid_d;
      done_q  <= done_d;
`ifdef IO_STIM_DRIVER_BOUNCE_EN
      prev_q  <= prev_d;
      stim_q  <= stim_d;
`endif
    end
  end

`ifdef IO_STIM_DRIVER_BOUNCE_EN
  assign o_stim = stim_q;
`else
  assign o_stim = pat_q;
`endif
  assign o_valid = valid_q;
  assign o_step  = step_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_io_stim_driver.sv
// Directed bench for io_stim_driver. Three instances cover the default
// configuration (CONST, LFSR, pause, abort, reset), an 8-bit INC wrap with
// no start delay, and a 4-bit two-channel WALK.
module tb_io_stim_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A: defaults (NUM_CH=2, WIDTH=32, START_DELAY=3, HOLD=4, STEPS=8)
  logic        en_a;
  logic [1:0]  mode_a;
  logic [63:0] seed_a, stim_a;
  logic        valid_a, done_a;
  logic [31:0] step_a;

  // Instance B: INC wrap (NUM_CH=1, WIDTH=8, START_DELAY=0, HOLD=1, STEPS=4)
  logic        en_b;
  logic [1:0]  mode_b;
  logic [7:0]  seed_b, stim_b;
  logic        valid_b, done_b;
  logic [31:0] step_b;

  // Instance C: WALK (NUM_CH=2, WIDTH=4, START_DELAY=1, HOLD=4, STEPS=5)
  logic        en_c;
  logic [1:0]  mode_c;
  logic [7:0]  seed_c, stim_c;
  logic        valid_c, done_c;
  logic [31:0] step_c;

  io_stim_driver u_a (
    .i_clk(clk), .i_rst(rst), .i_en(en_a), .i_mode(mode_a), .i_seed(seed_a),
    .o_stim(stim_a), .o_valid(valid_a), .o_step(step_a), .o_done(done_a)
  );

  io_stim_driver #(.NUM_CH(1), .WIDTH(8), .START_DELAY(0), .HOLD_CYCLES(1), .NUM_STEPS(4)) u_b (
    .i_clk(clk), .i_rst(rst), .i_en(en_b), .i_mode(mode_b), .i_seed(seed_b),
    .o_stim(stim_b), .o_valid(valid_b), .o_step(step_b), .o_done(done_b)
  );

  io_stim_driver #(.NUM_CH(2), .WIDTH(4), .START_DELAY(1), .HOLD_CYCLES(4), .NUM_STEPS(5)) u_c (
    .i_clk(clk), .i_rst(rst), .i_en(en_c), .i_mode(mode_c), .i_seed(seed_c),
    .o_stim(stim_c), .o_valid(valid_c), .o_step(step_c), .o_done(done_c)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [63:0] stim, input logic valid,
                       input logic [31:0] step, input logic done);
    check({tag, ".stim"},  stim_a,  stim);
    check({tag, ".valid"}, valid_a, valid);
    check({tag, ".step"},  step_a,  step);
    check({tag, ".done"},  done_a,  done);
  endtask

  // Outputs are observed on the falling edge, inputs change there too.
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  localparam logic [63:0] CONST_PAT = {32'hB5B5_B5B5, 32'hA5A5_A5A5};
  logic [7:0] walk_exp [5] = '{8'h21, 8'h42, 8'h84, 8'h18, 8'h21};
  logic [7:0] inc_exp  [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    en_a = 1'b0; mode_a = 2'd0; seed_a = '0;
    en_b = 1'b0; mode_b = 2'd0; seed_b = '0;
    en_c = 1'b0; mode_c = 2'd0; seed_c = '0;
    cycles(2);
    chk_a("reset_a", 64'h0, 1'b0, 32'd0, 1'b0);
    check("reset_b.stim", stim_b, 8'h00);
    check("reset_c.valid", valid_c, 1'b0);

    // Legacy CONST run, enable held from reset release.
    rst = 1'b0; en_a = 1'b1; mode_a = 2'd0; seed_a = CONST_PAT;
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      chk_a($sformatf("const_delay%0d", i), 64'h0, 1'b0, 32'd0, 1'b0);
    end
    cycles(1);
    chk_a("const_step0", CONST_PAT, 1'b1, 32'd0, 1'b0);
    cycles(3);
    chk_a("const_hold_end", CONST_PAT, 1'b1, 32'd0, 1'b0);
    cycles(1);
    chk_a("const_step1", CONST_PAT, 1'b1, 32'd1, 1'b0);
    // Changes after latching must be ignored.
    mode_a = 2'd1; seed_a = 64'h0;
    cycles(27);
    chk_a("const_last_hold", CONST_PAT, 1'b1, 32'd7, 1'b0);
    cycles(1);
    chk_a("const_done", CONST_PAT, 1'b0, 32'd7, 1'b1);
    cycles(3);
    chk_a("const_done_stay", CONST_PAT, 1'b0, 32'd7, 1'b1);
    en_a = 1'b0;
    cycles(1);
    chk_a("done_to_idle", 64'h0, 1'b0, 32'd0, 1'b0);

    // LFSR with zero seed, pause at step 2, then reset at step 3.
    mode_a = 2'd3; seed_a = 64'h0; en_a = 1'b1;
    cycles(3);
    chk_a("lfsr_delay", 64'h0, 1'b0, 32'd0, 1'b0);
    cycles(1);
    chk_a("lfsr_step0", {32'h0000_0001, 32'h0000_0001}, 1'b1, 32'd0, 1'b0);
    cycles(4);
    chk_a("lfsr_step1", {32'h8020_0003, 32'h8020_0003}, 1'b1, 32'd1, 1'b0);
    cycles(4);
    chk_a("lfsr_step2", {32'hC030_0002, 32'hC030_0002}, 1'b1, 32'd2, 1'b0);
    cycles(1);
    en_a = 1'b0;
    cycles(5);
    chk_a("pause", {32'hC030_0002, 32'hC030_0002}, 1'b1, 32'd2, 1'b0);
    en_a = 1'b1;
    cycles(2);
    chk_a("resume_hold", {32'hC030_0002, 32'hC030_0002}, 1'b1, 32'd2, 1'b0);
    cycles(1);
    chk_a("lfsr_step3", {32'h6018_0001, 32'h6018_0001}, 1'b1, 32'd3, 1'b0);
    rst = 1'b1;
    cycles(1);
    chk_a("reset_mid_run", 64'h0, 1'b0, 32'd0, 1'b0);
    rst = 1'b0;
    cycles(3);
    chk_a("restart_delay", 64'h0, 1'b0, 32'd0, 1'b0);
    cycles(1);
    chk_a("restart_step0", {32'h0000_0001, 32'h0000_0001}, 1'b1, 32'd0, 1'b0);

    // Abort during WAIT: valid must never rise.
    rst = 1'b1; en_a = 1'b0;
    cycles(1);
    rst = 1'b0; en_a = 1'b1;
    cycles(1);
    en_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycles(1);
      check($sformatf("abort_valid%0d", i), valid_a, 1'b0);
      check($sformatf("abort_stim%0d", i), stim_a, 64'h0);
    end

    // INC wrap, no start delay, one-cycle hold.
    mode_b = 2'd1; seed_b = 8'hFE; en_b = 1'b1;
    for (int n = 0; n < 4; n++) begin
      cycles(1);
      check($sformatf("inc_stim%0d", n), stim_b, inc_exp[n]);
      check($sformatf("inc_step%0d", n), step_b, 64'(n));
      check($sformatf("inc_valid%0d", n), valid_b, 1'b1);
    end
    cycles(1);
    check("inc_done", done_b, 1'b1);
    check("inc_done_valid", valid_b, 1'b0);
    check("inc_done_stim", stim_b, 8'h01);
    check("inc_done_step", step_b, 32'd3);

    // WALK on two 4-bit channels; seed must be ignored.
    mode_c = 2'd2; seed_c = 8'hFF; en_c = 1'b1;
    cycles(1);
    check("walk_wait_valid", valid_c, 1'b0);
    cycles(1);
    check("walk_stim0", stim_c, walk_exp[0]);
    check("walk_valid0", valid_c, 1'b1);
    for (int n = 1; n < 5; n++) begin
      cycles(3);
      check($sformatf("walk_hold%0d", n - 1), stim_c, walk_exp[n-1]);
      cycles(1);
      check($sformatf("walk_stim%0d", n), stim_c, walk_exp[n]);
      check($sformatf("walk_step%0d", n), step_c, 64'(n));
    end
    cycles(4);
    check("walk_done", done_c, 1'b1);
    check("walk_done_step", step_c, 32'd4);
    check("walk_done_stim", stim_c, 8'h21);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
